// File: rtl/cpu_pkg.sv
// Shared encodings for the multicycle CPU control path.
// Holds the controller state enum, the opcode/op field values used by
// instruction_decoder, and the memory-command, vsel, pc_sel, nsel and
// branch_en encodings that appear on the controller ports.
package cpu_pkg;

    // instruction[15:13]
    localparam logic [2:0] OPC_BRANCH = 3'b001;
    localparam logic [2:0] OPC_BL_BX  = 3'b010;
    localparam logic [2:0] OPC_LDR    = 3'b011;
    localparam logic [2:0] OPC_STR    = 3'b100;
    localparam logic [2:0] OPC_ALU    = 3'b101;
    localparam logic [2:0] OPC_MOV    = 3'b110;
    localparam logic [2:0] OPC_HALT   = 3'b111;

    // instruction[12:11], meaning depends on opcode
    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_CMP  = 2'b01;
    localparam logic [1:0] OP_AND  = 2'b10;
    localparam logic [1:0] OP_MVN  = 2'b11;
    localparam logic [1:0] OP_MOVR = 2'b00;
    localparam logic [1:0] OP_MOVI = 2'b10;
    localparam logic [1:0] OP_MEM  = 2'b00;
    localparam logic [1:0] OP_BX   = 2'b00;
    localparam logic [1:0] OP_BLX  = 2'b10;
    localparam logic [1:0] OP_BL   = 2'b11;

    // branch_en from the decoder
    localparam logic [1:0] BR_NONE = 2'b00;
    localparam logic [1:0] BR_REL  = 2'b01;
    localparam logic [1:0] BR_REG  = 2'b10;

    // register-file read select
    localparam logic [1:0] NSEL_RM = 2'b00;
    localparam logic [1:0] NSEL_RD = 2'b01;
    localparam logic [1:0] NSEL_RN = 2'b10;

    localparam logic [1:0] MNONE  = 2'b00;
    localparam logic [1:0] MREAD  = 2'b01;
    localparam logic [1:0] MWRITE = 2'b10;

    localparam logic [1:0] VSEL_C     = 2'b00;
    localparam logic [1:0] VSEL_PC    = 2'b01;
    localparam logic [1:0] VSEL_IMM8  = 2'b10;
    localparam logic [1:0] VSEL_MDATA = 2'b11;

    localparam logic [1:0] PC_RST = 2'b00;
    localparam logic [1:0] PC_INC = 2'b01;
    localparam logic [1:0] PC_REL = 2'b10;
    localparam logic [1:0] PC_REG = 2'b11;

    typedef enum logic [4:0] {
        S_RESET, S_IF1, S_IF2, S_UPD_PC, S_DECODE,
        S_WR_IMM, S_GET_A, S_GET_B, S_ALU, S_ALU_A, S_WB, S_CMP,
        S_ADDR, S_LD_ADDR, S_LD_MEM, S_LD_WB,
        S_ST_B, S_ST_C, S_ST_MEM,
        S_BRANCH, S_LINK, S_BX_B, S_BX_C, S_BX_PC,
        S_HALT
    } state_t;

endpackage

// File: rtl/cpu_controller.sv
// Moore sequencer for the multicycle CPU.
// Inputs : clk, rst_n (async, active low), opcode/op/branch_en from the
//          instruction decoder.
// Outputs: nsel back to the decoder; loada/loadb/loadc/loads, asel, bsel,
//          vsel, write to the datapath; load_ir, load_pc, pc_sel to the
//          IR/PC; addr_sel, load_addr, mem_cmd to the RAM interface;
//          halted while stopped.
// Every output depends only on the current state. The IR is stable from
// S_DECODE onward, so later states route on the live opcode/op.
module cpu_controller
    import cpu_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic [1:0] op,
    input  logic [1:0] branch_en,
    output logic [1:0] nsel,
    output logic       loada,
    output logic       loadb,
    output logic       loadc,
    output logic       loads,
    output logic       asel,
    output logic       bsel,
    output logic [1:0] vsel,
    output logic       write,
    output logic       load_ir,
    output logic       load_pc,
    output logic [1:0] pc_sel,
    output logic       addr_sel,
    output logic       load_addr,
    output logic [1:0] mem_cmd,
    output logic       halted
);

    state_t state, state_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_RESET;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = S_IF1;
        case (state)
            S_RESET:  state_nxt = S_IF1;
            S_IF1:    state_nxt = S_IF2;
            S_IF2:    state_nxt = S_UPD_PC;
            S_UPD_PC: state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OPC_MOV:    state_nxt = (op == OP_MOVI) ? S_WR_IMM :
                                            (op == OP_MOVR) ? S_GET_B  : S_IF1;
                    OPC_ALU:    state_nxt = (op == OP_MVN) ? S_GET_B : S_GET_A;
                    OPC_LDR,
                    OPC_STR:    state_nxt = (op == OP_MEM) ? S_GET_A : S_IF1;
                    OPC_BRANCH: state_nxt = (branch_en == BR_REL) ? S_BRANCH : S_IF1;
                    OPC_BL_BX:  state_nxt = (op == OP_BL || op == OP_BLX) ? S_LINK :
                                            (op == OP_BX)                 ? S_BX_B : S_IF1;
                    OPC_HALT:   state_nxt = S_HALT;
                    default:    state_nxt = S_IF1;
                endcase
            end
            // only ALU ops and LDR/STR reach S_GET_A
            S_GET_A:   state_nxt = (opcode == OPC_ALU) ? S_GET_B : S_ADDR;
            // MOV Rd,Rm and MVN pass B through with A forced to 0
            S_GET_B:   state_nxt = (opcode == OPC_ALU && op == OP_CMP) ? S_CMP :
                                   (opcode == OPC_ALU && op != OP_MVN) ? S_ALU : S_ALU_A;
            S_ALU,
            S_ALU_A:   state_nxt = S_WB;
            S_ADDR:    state_nxt = S_LD_ADDR;
            S_LD_ADDR: state_nxt = (opcode == OPC_LDR) ? S_LD_MEM : S_ST_B;
            S_LD_MEM:  state_nxt = S_LD_WB;
            S_ST_B:    state_nxt = S_ST_C;
            S_ST_C:    state_nxt = S_ST_MEM;
            S_LINK:    state_nxt = (op == OP_BL) ? S_BRANCH : S_BX_B;
            S_BX_B:    state_nxt = S_BX_C;
            S_BX_C:    state_nxt = S_BX_PC;
            S_HALT:    state_nxt = S_HALT;
            default:   state_nxt = S_IF1;
        endcase
    end

    always_comb begin
        nsel      = NSEL_RM;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        vsel      = VSEL_C;
        write     = 1'b0;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        pc_sel    = PC_RST;
        addr_sel  = 1'b0;
        load_addr = 1'b0;
        mem_cmd   = MNONE;
        halted    = 1'b0;
        case (state)
            S_RESET:   load_pc = 1'b1;
            S_IF1:     begin addr_sel = 1'b1; mem_cmd = MREAD; end
            S_IF2:     begin addr_sel = 1'b1; mem_cmd = MREAD; load_ir = 1'b1; end
            S_UPD_PC:  begin load_pc = 1'b1; pc_sel = PC_INC; end
            S_WR_IMM:  begin nsel = NSEL_RN; vsel = VSEL_IMM8; write = 1'b1; end
            S_GET_A:   begin nsel = NSEL_RN; loada = 1'b1; end
            S_GET_B:   begin nsel = NSEL_RM; loadb = 1'b1; end
            S_ALU:     loadc = 1'b1;
            S_ALU_A:   begin asel = 1'b1; loadc = 1'b1; end
            S_WB:      begin nsel = NSEL_RD; vsel = VSEL_C; write = 1'b1; end
            S_CMP:     loads = 1'b1;
            S_ADDR:    begin bsel = 1'b1; loadc = 1'b1; end
            S_LD_ADDR: load_addr = 1'b1;
            // read data arrives one cycle after the address, so MREAD spans both
            S_LD_MEM:  mem_cmd = MREAD;
            S_LD_WB:   begin mem_cmd = MREAD; nsel = NSEL_RD; vsel = VSEL_MDATA; write = 1'b1; end
            S_ST_B:    begin nsel = NSEL_RD; loadb = 1'b1; end
            S_ST_C:    begin asel = 1'b1; loadc = 1'b1; end
            S_ST_MEM:  mem_cmd = MWRITE;
            S_BRANCH:  begin load_pc = 1'b1; pc_sel = PC_REL; end
            // PC already holds the return address here
            S_LINK:    begin nsel = NSEL_RN; vsel = VSEL_PC; write = 1'b1; end
            S_BX_B:    begin nsel = NSEL_RD; loadb = 1'b1; end
            S_BX_C:    begin asel = 1'b1; loadc = 1'b1; end
            S_BX_PC:   begin load_pc = 1'b1; pc_sel = PC_REG; end
            S_HALT:    halted = 1'b1;
            default:   ;
        endcase
    end

endmodule
